ddr3_init_seq: RTL

DDR3_INIT_SEQ -- requirements
Module: ddr3_init_seq

---
 rtl/ddr3_init_seq_if.sv | 37 +++
 rtl/ddr3_init_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_init_seq_if.sv
// DFI-style command/control bundle driven by the DDR3 power-up sequencer.
interface ddr3_init_seq_if #(
    parameter int unsigned DDR_ROW_BITS = 13
);
    logic                    dfi_reset_n_o;
    logic                    dfi_cke_o;
    logic                    dfi_cs_n_o;
    logic                    dfi_ras_n_o;
    logic                    dfi_cas_n_o;
    logic                    dfi_we_n_o;
    logic [2:0]              dfi_bank_o;
    logic [DDR_ROW_BITS-1:0] dfi_addr_o;

    // Sequencer side drives the memory pins.
    modport master (
        output dfi_reset_n_o,
        output dfi_cke_o,
        output dfi_cs_n_o,
        output dfi_ras_n_o,
        output dfi_cas_n_o,
        output dfi_we_n_o,
        output dfi_bank_o,
        output dfi_addr_o
    );

    // PHY / memory model side observes them.
    modport slave (
        input dfi_reset_n_o,
        input dfi_cke_o,
        input dfi_cs_n_o,
        input dfi_ras_n_o,
        input dfi_cas_n_o,
        input dfi_we_n_o,
        input dfi_bank_o,
        input dfi_addr_o
    );
endinterface

// File: rtl/ddr3_init_seq.sv
// DDR3 power-up sequencer: RESET#/CKE timing, MR2/MR3/MR1/MR0 loads, ZQCL, done.
module ddr3_init_seq #(
    parameter int unsigned CYCLES_RESET = 20000,
    parameter int unsigned CYCLES_WAKE  = 50000,
    parameter int unsigned CYCLES_XPR   = 13,
    parameter int unsigned DDR_CMRD     = 4,
    parameter int unsigned DDR_CMOD     = 12,
    parameter int unsigned DDR_CZQINIT  = 512,
    parameter int unsigned DDR_ROW_BITS = 13,
    parameter logic [DDR_ROW_BITS-1:0] MR0_VAL = DDR_ROW_BITS'(13'h0320),
    parameter logic [DDR_ROW_BITS-1:0] MR1_VAL = DDR_ROW_BITS'(13'h0001),
    parameter logic [DDR_ROW_BITS-1:0] MR2_VAL = DDR_ROW_BITS'(13'h0008),
    parameter logic [DDR_ROW_BITS-1:0] MR3_VAL = DDR_ROW_BITS'(13'h0000)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable_i,
    ddr3_init_seq_if.master dfi,
    output logic            done_o
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAX_DLY = max2(max2(max2(CYCLES_RESET, CYCLES_WAKE),
                                                max2(CYCLES_XPR, DDR_CMRD)),
                                           max2(DDR_CMOD, DDR_CZQINIT));
    localparam int unsigned CNT_W = $clog2(MAX_DLY) + 1;

    // Command encoding {CS#, RAS#, CAS#, WE#}.
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_MRS  = 4'b0000;
    localparam logic [3:0] CMD_ZQCL = 4'b0110;

    // ZQCL long calibration: A10 high, everything else low.
    localparam logic [DDR_ROW_BITS-1:0] ZQ_ADDR = DDR_ROW_BITS'(1) << 10;

    // Reload values: a delay of N cycles counts N-1 down to zero.
    localparam logic [CNT_W-1:0] LD_RESET = CNT_W'(CYCLES_RESET - 1);
    localparam logic [CNT_W-1:0] LD_WAKE  = CNT_W'(CYCLES_WAKE - 1);
    localparam logic [CNT_W-1:0] LD_XPR   = CNT_W'(CYCLES_XPR - 1);
    localparam logic [CNT_W-1:0] LD_MRD   = CNT_W'(DDR_CMRD - 1);
    localparam logic [CNT_W-1:0] LD_MOD   = CNT_W'(DDR_CMOD - 1);
    localparam logic [CNT_W-1:0] LD_ZQ    = CNT_W'(DDR_CZQINIT - 1);

    // Each MRx/ZQCL state means "that command has just been issued; waiting for the next".
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_RST  = 4'd1,
        ST_WAKE = 4'd2,
        ST_CKE  = 4'd3,
        ST_MR2  = 4'd4,
        ST_MR3  = 4'd5,
        ST_MR1  = 4'd6,
        ST_MR0  = 4'd7,
        ST_ZQCL = 4'd8,
        ST_DONE = 4'd9
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    reset_n_q, reset_n_d;
    logic                    cke_q, cke_d;
    logic [3:0]              cmd_q, cmd_d;
    logic [2:0]              bank_q, bank_d;
    logic [DDR_ROW_BITS-1:0] addr_q, addr_d;
    logic                    done_q, done_d;

    logic cnt_zero;
    assign cnt_zero = (cnt_q == '0);

    // State, delay counter and all pin registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            reset_n_q <= 1'b0;
            cke_q     <= 1'b0;
            cmd_q     <= CMD_NOP;
            bank_q    <= '0;
            addr_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            reset_n_q <= reset_n_d;
            cke_q     <= cke_d;
            cmd_q     <= cmd_d;
            bank_q    <= bank_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
        end
    end

    // Next state and next pin values; commands default to a one-cycle NOP.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
        reset_n_d = reset_n_q;
        cke_d     = cke_q;
        done_d    = done_q;
        cmd_d     = CMD_NOP;
        bank_d    = '0;
        addr_d    = '0;

        case (state_q)
            ST_IDLE: begin
                reset_n_d = 1'b0;
                cke_d     = 1'b0;
                done_d    = 1'b0;
                if (enable_i) begin
                    state_d = ST_RST;
                    cnt_d   = LD_RESET;
                end
            end
            ST_RST: begin
                if (cnt_zero) begin
                    reset_n_d = 1'b1;
                    state_d   = ST_WAKE;
                    cnt_d     = LD_WAKE;
                end
            end
            ST_WAKE: begin
                if (cnt_zero) begin
                    cke_d   = 1'b1;
                    state_d = ST_CKE;
                    cnt_d   = LD_XPR;
                end
            end
            ST_CKE: begin
                if (cnt_zero) begin
                    cmd_d   = CMD_MRS;
                    bank_d  = 3'd2;
                    addr_d  = MR2_VAL;
                    state_d = ST_MR2;
                    cnt_d   = LD_MRD;
                end
            end
            ST_MR2: begin
                if (cnt_zero) begin
                    cmd_d   = CMD_MRS;
                    bank_d  = 3'd3;
                    addr_d  = MR3_VAL;
                    state_d = ST_MR3;
                    cnt_d   = LD_MRD;
                end
            end
            ST_MR3: begin
                if (cnt_zero) begin
                    cmd_d   = CMD_MRS;
                    bank_d  = 3'd1;
                    addr_d  = MR1_VAL;
                    state_d = ST_MR1;
                    cnt_d   = LD_MRD;
                end
            end
            ST_MR1: begin
                if (cnt_zero) begin
                    cmd_d   = CMD_MRS;
                    bank_d  = 3'd0;
                    addr_d  = MR0_VAL;
                    state_d = ST_MR0;
                    cnt_d   = LD_MOD;
                end
            end
            ST_MR0: begin
                if (cnt_zero) begin
                    cmd_d   = CMD_ZQCL;
                    addr_d  = ZQ_ADDR;
                    state_d = ST_ZQCL;
                    cnt_d   = LD_ZQ;
                end
            end
            ST_ZQCL: begin
                if (cnt_zero) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                reset_n_d = 1'b1;
                cke_d     = 1'b1;
                done_d    = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dfi.dfi_reset_n_o = reset_n_q;
    assign dfi.dfi_cke_o     = cke_q;
    assign dfi.dfi_cs_n_o    = cmd_q[3];
    assign dfi.dfi_ras_n_o   = cmd_q[2];
    assign dfi.dfi_cas_n_o   = cmd_q[1];
    assign dfi.dfi_we_n_o    = cmd_q[0];
    assign dfi.dfi_bank_o    = bank_q;
    assign dfi.dfi_addr_o    = addr_q;
    assign done_o            = done_q;

endmodule
